// File: rtl/spi_slave_shift.sv
// rtl/spi_slave_shift.sv - full-duplex SPI slave shift engine, all CPOL/CPHA modes, frame error detect
module spi_slave_shift #(
   parameter int LENGTH      = 64,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [LENGTH-1:0] tx_data,
   output logic [LENGTH-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CW = $clog2(LENGTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(LENGTH);
   localparam logic [CW-1:0] CNT_OVER = CW'(LENGTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_d;
   logic                   cs_d;

   logic [LENGTH-2:0]      tx_sr;
   logic [LENGTH-2:0]      rx_sr;
   logic [CW-1:0]          cnt;
   logic                   first_edge;

   logic                   sck_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   lead_edge;
   logic                   trail_edge;
   logic                   sample_edge;
   logic                   shift_edge;
   logic                   cs_fall;
   logic                   cs_rise;
   logic [LENGTH-1:0]      rx_next;

   // Pin synchronisers plus one extra stage on sck/cs for edge detection.
   // cs is assumed low out of reset so a pin already low at release never
   // looks like a falling edge; a spurious rise is harmless while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync  <= {SYNC_STAGES{CPOL}};
         cs_sync   <= '0;
         mosi_sync <= '0;
         sck_d     <= CPOL;
         cs_d      <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_d     <= sck_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   // Edge classification in terms of the configured SPI mode.
   always_comb begin
      sck_s       = sck_sync[SYNC_STAGES-1];
      cs_s        = cs_sync[SYNC_STAGES-1];
      mosi_s      = mosi_sync[SYNC_STAGES-1];
      sck_rise    = sck_s & ~sck_d;
      sck_fall    = ~sck_s & sck_d;
      lead_edge   = CPOL ? sck_fall : sck_rise;
      trail_edge  = CPOL ? sck_rise : sck_fall;
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge : trail_edge;
      cs_fall     = ~cs_s & cs_d;
      cs_rise     = cs_s & ~cs_d;
      rx_next     = {rx_sr, mosi_s};
   end

   // Frame control, shift paths and status pulses; cs events take priority
   // over any sck edge landing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sr      <= '0;
         rx_sr      <= '0;
         cnt        <= '0;
         first_edge <= 1'b0;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         busy       <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (cs_fall) begin
            tx_sr      <= tx_data[LENGTH-2:0];
            miso       <= tx_data[LENGTH-1];
            cnt        <= '0;
            first_edge <= 1'b1;
            busy       <= 1'b1;
            miso_oe    <= 1'b1;
         end else if (cs_rise) begin
            if (busy) begin
               busy      <= 1'b0;
               miso_oe   <= 1'b0;
               miso      <= 1'b0;
               frame_err <= (cnt != CNT_FULL);
            end
         end else if (busy && !cs_s) begin
            if (sample_edge) begin
               if (cnt < CNT_FULL) begin
                  rx_sr <= rx_next[LENGTH-2:0];
                  cnt   <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
                  end
               end else begin
                  cnt <= CNT_OVER;
               end
            end
            if (shift_edge) begin
               // In CPHA=1 the first leading edge only arms shifting so the MSB stays on the pin.
               if (CPHA && first_edge) begin
                  first_edge <= 1'b0;
               end else begin
                  miso  <= tx_sr[LENGTH-2];
                  tx_sr <= tx_sr << 1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_shift.sv
// tb/tb_spi_slave_shift.sv - self-checking bench for spi_slave_shift in all four SPI modes
module tb_spi_slave_shift;

   logic        clk = 1'b0;
   logic        rst;
   logic        sck_w [4];
   logic        cs_w  [4];
   logic        mosi_w[4];
   logic        miso_w[4];
   logic        oe_w  [4];
   logic        rv_w  [4];
   logic        fe_w  [4];
   logic        bz_w  [4];
   logic [15:0] tx_w  [4];
   logic [7:0]  rx0;
   logic [15:0] rx_w  [1:3];

   int vcnt[4] = '{0, 0, 0, 0};
   int ecnt[4] = '{0, 0, 0, 0};
   int both_cnt = 0;
   int n_pass = 0;
   int n_total = 0;
   logic [15:0] prev_rx[4];

   typedef struct {
      int          m;
      int          nbits;
      logic [15:0] tx;
      logic [15:0] mo;
      logic [15:0] cap;
      logic [15:0] rx;
      int          v;
      int          e;
   } vec_t;

   always #5 clk = ~clk;

   spi_slave_shift #(.LENGTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .rst(rst), .sck(sck_w[0]), .cs(cs_w[0]), .mosi(mosi_w[0]),
      .miso(miso_w[0]), .miso_oe(oe_w[0]), .tx_data(tx_w[0][7:0]), .rx_data(rx0),
      .rx_valid(rv_w[0]), .frame_err(fe_w[0]), .busy(bz_w[0]));
   spi_slave_shift #(.LENGTH(16), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) dut1 (
      .clk(clk), .rst(rst), .sck(sck_w[1]), .cs(cs_w[1]), .mosi(mosi_w[1]),
      .miso(miso_w[1]), .miso_oe(oe_w[1]), .tx_data(tx_w[1]), .rx_data(rx_w[1]),
      .rx_valid(rv_w[1]), .frame_err(fe_w[1]), .busy(bz_w[1]));
   spi_slave_shift #(.LENGTH(16), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .sck(sck_w[2]), .cs(cs_w[2]), .mosi(mosi_w[2]),
      .miso(miso_w[2]), .miso_oe(oe_w[2]), .tx_data(tx_w[2]), .rx_data(rx_w[2]),
      .rx_valid(rv_w[2]), .frame_err(fe_w[2]), .busy(bz_w[2]));
   spi_slave_shift #(.LENGTH(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut3 (
      .clk(clk), .rst(rst), .sck(sck_w[3]), .cs(cs_w[3]), .mosi(mosi_w[3]),
      .miso(miso_w[3]), .miso_oe(oe_w[3]), .tx_data(tx_w[3]), .rx_data(rx_w[3]),
      .rx_valid(rv_w[3]), .frame_err(fe_w[3]), .busy(bz_w[3]));

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rv_w[k]) vcnt[k] <= vcnt[k] + 1;
         if (fe_w[k]) ecnt[k] <= ecnt[k] + 1;
         if (rv_w[k] && fe_w[k]) both_cnt <= both_cnt + 1;
      end
   end

   function automatic int len_of(input int m);
      return (m == 0) ? 8 : 16;
   endfunction

   function automatic logic [15:0] rx_of(input int m);
      if (m == 0) return {8'h00, rx0};
      return rx_w[m];
   endfunction

   task automatic wt(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // SPI master for mode m: drives nbits clocks, collects miso bits as the master would.
   task automatic xfer(input int m, input int nbits, input logic [15:0] tx, input logic [15:0] mo,
                       output logic [15:0] cap, output logic [15:0] ext,
                       output logic mid_busy, output logic mid_oe);
      int   len;
      logic cpol;
      logic cpha;
      logic b;
      logic smp;
      len  = len_of(m);
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      tx_w[m] = tx;
      cap = '0; ext = '0; mid_busy = 1'b0; mid_oe = 1'b0; smp = 1'b0;
      wt(4);
      cs_w[m] = 1'b0;
      wt(8);
      for (int i = 0; i < nbits; i++) begin
         b = (i < len) ? mo[len-1-i] : 1'b1;
         if (!cpha) begin
            mosi_w[m] = b;
            wt(8);
            sck_w[m] = ~cpol;
            smp = miso_w[m];
            wt(8);
            sck_w[m] = cpol;
         end else begin
            wt(8);
            sck_w[m] = ~cpol;
            mosi_w[m] = b;
            wt(8);
            sck_w[m] = cpol;
            smp = miso_w[m];
         end
         if (i < len) cap = {cap[14:0], smp};
         else ext = {ext[14:0], smp};
         if (i == 0) begin
            mid_busy = bz_w[m];
            mid_oe   = oe_w[m];
         end
      end
      wt(8);
      cs_w[m] = 1'b1;
      wt(12);
   endtask

   task automatic run_check(input string tag, input vec_t t);
      int          v0, e0;
      logic [15:0] cap, ext;
      logic        mb, mo_e;
      v0 = vcnt[t.m];
      e0 = ecnt[t.m];
      xfer(t.m, t.nbits, t.tx, t.mo, cap, ext, mb, mo_e);
      chk({tag, " miso_word"}, cap, t.cap);
      if (t.nbits > len_of(t.m)) chk({tag, " miso_tail"}, ext, 16'h0);
      chk({tag, " rx_data"}, rx_of(t.m), t.rx);
      chk({tag, " rx_valid_cnt"}, vcnt[t.m] - v0, t.v);
      chk({tag, " frame_err_cnt"}, ecnt[t.m] - e0, t.e);
      if (t.nbits > 0) chk({tag, " busy_oe_mid"}, {mb, mo_e}, 2'b11);
      chk({tag, " idle_after"}, {bz_w[t.m], oe_w[t.m], miso_w[t.m]}, 3'b000);
   endtask

   initial begin
      vec_t tbl[7];
      vec_t t;
      int   v0, e0, k, len;

      tbl[0] = '{0,  8, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C, 1, 0};
      tbl[1] = '{1, 16, 16'h8001, 16'hF00F, 16'h8001, 16'hF00F, 1, 0};
      tbl[2] = '{2, 16, 16'h8001, 16'hF00F, 16'h8001, 16'hF00F, 1, 0};
      tbl[3] = '{3, 16, 16'h8001, 16'hF00F, 16'h8001, 16'hF00F, 1, 0};
      tbl[4] = '{0,  5, 16'h005A, 16'h00FF, 16'h000B, 16'h003C, 0, 1};
      tbl[5] = '{0, 10, 16'h00C3, 16'h0096, 16'h00C3, 16'h0096, 1, 1};
      tbl[6] = '{0,  0, 16'h0077, 16'h0000, 16'h0000, 16'h0096, 0, 1};

      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sck_w[i] = (i >= 2);
         cs_w[i] = 1'b1;
         mosi_w[i] = 1'b0;
         tx_w[i] = '0;
      end
      wt(3);
      for (int i = 0; i < 4; i++)
         chk($sformatf("reset_vals%0d", i),
             {miso_w[i], oe_w[i], bz_w[i], rv_w[i], fe_w[i], rx_of(i)}, 21'h0);
      rst = 1'b0;
      wt(10);

      for (int i = 0; i < 7; i++) run_check($sformatf("vec%0d", i), tbl[i]);
      prev_rx = '{16'h0096, 16'hF00F, 16'hF00F, 16'hF00F};

      for (int i = 0; i < 12; i++) begin
         k   = $urandom_range(0, 3);
         len = len_of(k);
         t.m = k;
         t.nbits = $urandom_range(len - 3, len + 2);
         t.tx = 16'($urandom) & ((len == 8) ? 16'h00FF : 16'hFFFF);
         t.mo = 16'($urandom) & ((len == 8) ? 16'h00FF : 16'hFFFF);
         if (t.nbits >= len) begin
            t.cap = t.tx;
            t.rx  = t.mo;
            t.v   = 1;
            prev_rx[k] = t.mo;
         end else begin
            t.cap = t.tx >> (len - t.nbits);
            t.rx  = prev_rx[k];
            t.v   = 0;
         end
         t.e = (t.nbits != len) ? 1 : 0;
         run_check($sformatf("rnd%0d_m%0d_n%0d", i, k, t.nbits), t);
      end

      v0 = vcnt[0];
      e0 = ecnt[0];
      tx_w[0] = 16'h005A;
      cs_w[0] = 1'b0;
      wt(8);
      for (int i = 0; i < 3; i++) begin
         mosi_w[0] = 1'b1;
         wt(8);
         sck_w[0] = 1'b1;
         wt(8);
         sck_w[0] = 1'b0;
      end
      wt(4);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {miso_w[0], oe_w[0], bz_w[0], rx0}, 11'h0);
      wt(2);
      rst = 1'b0;
      wt(12);
      chk("no_start_cs_low", {bz_w[0], oe_w[0]}, 2'b00);
      cs_w[0] = 1'b1;
      wt(12);
      chk("abort_no_pulses", (vcnt[0] - v0) + (ecnt[0] - e0), 0);

      t = '{0, 8, 16'h0011, 16'h0081, 16'h0011, 16'h0081, 1, 0};
      run_check("b2b_first", t);
      t = '{0, 8, 16'h0022, 16'h007E, 16'h0022, 16'h007E, 1, 0};
      run_check("b2b_second", t);

      chk("pulses_never_together", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
